// File: rtl/multicycle_adder.sv
// rtl/multicycle_adder.sv - multi-cycle ripple-carry adder, one CHUNK-bit slice per cycle
// Operands are shifted through a single CHUNK-bit adder; the carry register links the slices.
module multicycle_adder #(
  parameter int NBITS = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             istream_val,
  output logic             istream_rdy,
  input  logic [NBITS-1:0] in0,
  input  logic [NBITS-1:0] in1,
  input  logic             cin,
  output logic             ostream_val,
  input  logic             ostream_rdy,
  output logic [NBITS-1:0] out,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNKS = NBITS / CHUNK;
  localparam int CW      = (NCHUNKS > 1) ? $clog2(NCHUNKS) : 1;

  generate
    if (CHUNK < 1 || (NBITS % CHUNK) != 0) begin : g_bad_params
      $error("multicycle_adder: CHUNK must be >= 1 and divide NBITS");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [NBITS-1:0] a_q, a_d;
  logic [NBITS-1:0] b_q, b_d;
  logic [NBITS-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    count_q, count_d;

  logic [CHUNK:0]   slice;
  logic             slice_c;
  logic [CHUNK-1:0] slice_s;
  logic             carry_into_msb;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    count_d = count_q;

    slice   = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + (CHUNK+1)'(carry_q);
    slice_c = slice[CHUNK];
    slice_s = slice[CHUNK-1:0];
    // The carry entering the slice MSB is recovered from the sum bit and both addend bits.
    carry_into_msb = slice_s[CHUNK-1] ^ a_q[CHUNK-1] ^ b_q[CHUNK-1];

    case (state_q)
      IDLE: begin
        if (istream_val) begin
          a_d     = in0;
          b_d     = in1;
          carry_d = cin;
          count_d = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        sum_d   = (sum_q >> CHUNK) | (NBITS'(slice_s) << (NBITS - CHUNK));
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = slice_c;
        count_d = count_q + CW'(1);
        if (count_q == CW'(NCHUNKS - 1)) begin
          ovf_d   = carry_into_msb ^ slice_c;
          state_d = DONE;
        end
      end
      DONE: begin
        if (ostream_rdy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

  // Result outputs are masked outside DONE so partial sums never leak.
  always_comb begin
    istream_rdy = (state_q == IDLE) && !rst;
    ostream_val = (state_q == DONE);
    out         = ostream_val ? sum_q : '0;
    cout        = ostream_val ? carry_q : 1'b0;
    ovf         = ostream_val ? ovf_q : 1'b0;
  end

endmodule

// File: tb/tb_multicycle_adder.sv
// tb/tb_multicycle_adder.sv - directed and random checks of multicycle_adder
// Three instances: 8/2 (main), 8/8 (single chunk) and 32/4 (random golden compare).
module tb_multicycle_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic       ival_a = 0, irdy_a, oval_a, ordy_a = 0, cin_a = 0, cout_a, ovf_a;
  logic [7:0] in0_a = 0, in1_a = 0, out_a;
  logic       ival_b = 0, irdy_b, oval_b, ordy_b = 1, cin_b = 0, cout_b, ovf_b;
  logic [7:0] in0_b = 0, in1_b = 0, out_b;
  logic        ival_c = 0, irdy_c, oval_c, ordy_c = 1, cin_c = 0, cout_c, ovf_c;
  logic [31:0] in0_c = 0, in1_c = 0, out_c;

  multicycle_adder #(.NBITS(8), .CHUNK(2)) u_a (
    .clk(clk), .rst(rst), .istream_val(ival_a), .istream_rdy(irdy_a), .in0(in0_a), .in1(in1_a),
    .cin(cin_a), .ostream_val(oval_a), .ostream_rdy(ordy_a), .out(out_a), .cout(cout_a), .ovf(ovf_a));
  multicycle_adder #(.NBITS(8), .CHUNK(8)) u_b (
    .clk(clk), .rst(rst), .istream_val(ival_b), .istream_rdy(irdy_b), .in0(in0_b), .in1(in1_b),
    .cin(cin_b), .ostream_val(oval_b), .ostream_rdy(ordy_b), .out(out_b), .cout(cout_b), .ovf(ovf_b));
  multicycle_adder #(.NBITS(32), .CHUNK(4)) u_c (
    .clk(clk), .rst(rst), .istream_val(ival_c), .istream_rdy(irdy_c), .in0(in0_c), .in1(in1_c),
    .cin(cin_c), .ostream_val(oval_c), .ostream_rdy(ordy_c), .out(out_c), .cout(cout_c), .ovf(ovf_c));

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1);
  end

  // Drives one operand pair into u_a and waits for the result; leaves u_a in DONE.
  task automatic send_a(input logic [7:0] x, input logic [7:0] y, input logic c,
                        output int lat, output logic [7:0] o, output logic co, output logic ov);
    for (int k = 0; k < 10 && !irdy_a; k++) begin
      @(posedge clk); #1;
    end
    in0_a = x; in1_a = y; cin_a = c; ival_a = 1;
    @(posedge clk); #1;
    ival_a = 0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (oval_a) begin
        lat = k;
        break;
      end
    end
    o = out_a; co = cout_a; ov = ovf_a;
  endtask

  task automatic ack_a();
    ordy_a = 1;
    @(posedge clk); #1;
    ordy_a = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    @(posedge clk); #1;
    n_checks++;
    if (irdy_a !== 1'b0 || oval_a !== 1'b0) begin
      n_fail++; $display("FAIL reset_handshake: rdy=%b val=%b, required rdy=0 val=0", irdy_a, oval_a);
    end
    n_checks++;
    if (out_a !== 8'h00 || cout_a !== 1'b0 || ovf_a !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: out=%h cout=%b ovf=%b, required 00 0 0", out_a, cout_a, ovf_a);
    end
    rst = 0;
    #1;
    n_checks++;
    if (irdy_a !== 1'b1 || irdy_b !== 1'b1 || irdy_c !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_rdy: rdy a/b/c=%b%b%b, required 111", irdy_a, irdy_b, irdy_c);
    end
  endtask

  task automatic test_basic();
    int lat; logic [7:0] o; logic co, ov;
    send_a(8'h0F, 8'h01, 1'b0, lat, o, co, ov);
    n_checks++;
    if (lat !== 4) begin
      n_fail++; $display("FAIL basic_latency: got %0d cycles, required 4", lat);
    end
    n_checks++;
    if (o !== 8'h10 || co !== 1'b0 || ov !== 1'b0) begin
      n_fail++; $display("FAIL basic_sum: out=%h cout=%b ovf=%b, required 10 0 0", o, co, ov);
    end
    ack_a();
  endtask

  task automatic test_carry_in();
    int lat; logic [7:0] o; logic co, ov;
    send_a(8'hFF, 8'h00, 1'b1, lat, o, co, ov);
    n_checks++;
    if (o !== 8'h00 || co !== 1'b1 || ov !== 1'b0) begin
      n_fail++; $display("FAIL carry_in_wrap: out=%h cout=%b ovf=%b, required 00 1 0", o, co, ov);
    end
    ack_a();
  endtask

  task automatic test_overflow();
    int lat; logic [7:0] o; logic co, ov;
    send_a(8'h7F, 8'h01, 1'b0, lat, o, co, ov);
    n_checks++;
    if (o !== 8'h80 || co !== 1'b0 || ov !== 1'b1) begin
      n_fail++; $display("FAIL ovf_pos: out=%h cout=%b ovf=%b, required 80 0 1", o, co, ov);
    end
    ack_a();
    send_a(8'h80, 8'h80, 1'b0, lat, o, co, ov);
    n_checks++;
    if (o !== 8'h00 || co !== 1'b1 || ov !== 1'b1) begin
      n_fail++; $display("FAIL ovf_neg: out=%h cout=%b ovf=%b, required 00 1 1", o, co, ov);
    end
    ack_a();
    send_a(8'hC0, 8'h40, 1'b0, lat, o, co, ov);
    n_checks++;
    if (o !== 8'h00 || co !== 1'b1 || ov !== 1'b0) begin
      n_fail++; $display("FAIL ovf_none: out=%h cout=%b ovf=%b, required 00 1 0", o, co, ov);
    end
    ack_a();
  endtask

  task automatic test_backpressure();
    int lat; logic [7:0] o; logic co, ov;
    int bad = 0;
    send_a(8'h12, 8'h34, 1'b0, lat, o, co, ov);
    for (int k = 0; k < 5; k++) begin
      in0_a = 8'(k * 37); in1_a = 8'(k * 91 + 5); ival_a = k[0];
      @(posedge clk); #1;
      if (oval_a !== 1'b1 || irdy_a !== 1'b0 || out_a !== 8'h46) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL backpressure_hold: %0d bad cycles, last val=%b rdy=%b out=%h, required 1 0 46",
                         bad, oval_a, irdy_a, out_a);
    end
    ival_a = 0;
    ack_a();
    n_checks++;
    if (irdy_a !== 1'b1 || oval_a !== 1'b0 || out_a !== 8'h00) begin
      n_fail++; $display("FAIL backpressure_release: rdy=%b val=%b out=%h, required 1 0 00", irdy_a, oval_a, out_a);
    end
  endtask

  task automatic test_reset_mid_calc();
    int lat; logic [7:0] o; logic co, ov;
    in0_a = 8'hAA; in1_a = 8'h55; cin_a = 1; ival_a = 1;
    @(posedge clk); #1;
    ival_a = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1;
    #1;
    n_checks++;
    if (irdy_a !== 1'b0 || oval_a !== 1'b0 || out_a !== 8'h00) begin
      n_fail++; $display("FAIL reset_mid_calc: rdy=%b val=%b out=%h, required 0 0 00", irdy_a, oval_a, out_a);
    end
    @(posedge clk); #1;
    rst = 0;
    #1;
    send_a(8'h12, 8'h34, 1'b0, lat, o, co, ov);
    n_checks++;
    if (lat !== 4 || o !== 8'h46 || co !== 1'b0 || ov !== 1'b0) begin
      n_fail++; $display("FAIL after_reset_txn: lat=%0d out=%h cout=%b ovf=%b, required 4 46 0 0", lat, o, co, ov);
    end
    ack_a();
  endtask

  task automatic test_back_to_back();
    logic [7:0] va [3] = '{8'h0F, 8'hFF, 8'h7F};
    logic [7:0] vb [3] = '{8'h01, 8'h01, 8'h00};
    logic       vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [9:0] ex [3] = '{{1'b0, 1'b0, 8'h10}, {1'b1, 1'b0, 8'h00}, {1'b0, 1'b1, 8'h80}};
    int acc_cyc [3];
    int res_cyc [3];
    int sent = 0, got = 0;
    for (int cyc = 0; cyc < 30 && got < 3; cyc++) begin
      if (oval_b) begin
        res_cyc[got] = cyc;
        n_checks++;
        if ({cout_b, ovf_b, out_b} !== ex[got]) begin
          n_fail++; $display("FAIL b2b_result%0d: cout/ovf/out=%b/%b/%h, required %b/%b/%h",
                             got, cout_b, ovf_b, out_b, ex[got][9], ex[got][8], ex[got][7:0]);
        end
        got++;
      end
      if (irdy_b && sent < 3) begin
        in0_b = va[sent]; in1_b = vb[sent]; cin_b = vc[sent]; ival_b = 1;
        acc_cyc[sent] = cyc + 1;
        sent++;
      end else begin
        ival_b = 0;
      end
      @(posedge clk); #1;
    end
    ival_b = 0;
    n_checks++;
    if (got != 3) begin
      n_fail++; $display("FAIL b2b_count: got %0d results, required 3", got);
    end else begin
      n_checks++;
      if (res_cyc[0] - acc_cyc[0] != 1 || res_cyc[2] - acc_cyc[2] != 1) begin
        n_fail++; $display("FAIL b2b_latency: %0d and %0d cycles, required 1", res_cyc[0] - acc_cyc[0],
                           res_cyc[2] - acc_cyc[2]);
      end
      n_checks++;
      if (res_cyc[1] - res_cyc[0] != 3 || res_cyc[2] - res_cyc[1] != 3) begin
        n_fail++; $display("FAIL b2b_spacing: %0d and %0d cycles, required 3", res_cyc[1] - res_cyc[0],
                           res_cyc[2] - res_cyc[1]);
      end
    end
  endtask

  task automatic test_random_32();
    logic [31:0] a, b;
    logic        c;
    logic [32:0] g;
    logic        g_ovf;
    int          done;
    for (int n = 0; n < 1000; n++) begin
      a = $urandom; b = $urandom; c = 1'($urandom_range(0, 1));
      if (n == 0) begin a = 32'hFFFF_FFFF; b = 32'h0; c = 1'b1; end
      if (n == 1) begin a = 32'h7FFF_FFFF; b = 32'h1; c = 1'b0; end
      g = {1'b0, a} + {1'b0, b} + 33'(c);
      g_ovf = (a[31] == b[31]) && (g[31] != a[31]);
      for (int k = 0; k < 10 && !irdy_c; k++) begin
        @(posedge clk); #1;
      end
      in0_c = a; in1_c = b; cin_c = c; ival_c = 1;
      @(posedge clk); #1;
      ival_c = 0;
      done = 0;
      for (int k = 0; k < 20 && !done; k++) begin
        @(posedge clk); #1;
        if (oval_c) done = 1;
      end
      n_checks++;
      if (!done || out_c !== g[31:0] || cout_c !== g[32] || ovf_c !== g_ovf) begin
        n_fail++; $display("FAIL rand32_%0d: done=%0d out=%h cout=%b ovf=%b, required %h %b %b (a=%h b=%h cin=%b)",
                           n, done, out_c, cout_c, ovf_c, g[31:0], g[32], g_ovf, a, b, c);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_in();
    test_overflow();
    test_backpressure();
    test_reset_mid_calc();
    test_back_to_back();
    test_random_32();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
